// File: rtl/opl2_uart_reg_sequencer_if.sv
// Byte-stream and register-write bus between the UART receiver, the pair
// sequencer and the OPL2 core register port.
interface opl2_uart_reg_sequencer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_eop;
  logic               opl_busy;
  logic               opl_wr;
  logic [7:0]         opl_addr;
  logic [7:0]         opl_data;
  logic [LEVEL_W-1:0] fifo_level;
  logic               overflow;
  logic               frame_err;
  logic [15:0]        wr_count;

  // Sequencer side: consumes bytes and busy, produces write strobes and status.
  modport slave (
    input  rx_valid, rx_data, rx_eop, opl_busy,
    output opl_wr, opl_addr, opl_data, fifo_level, overflow, frame_err, wr_count
  );

  // Environment side: UART receiver plus OPL2 core.
  modport master (
    output rx_valid, rx_data, rx_eop, opl_busy,
    input  opl_wr, opl_addr, opl_data, fifo_level, overflow, frame_err, wr_count
  );
endinterface

// File: rtl/opl2_uart_reg_sequencer.sv
// Turns the UART byte stream into (address, data) register pairs, buffers
// them in a small FIFO and issues them to the OPL2 core as single-cycle
// write strobes with a guaranteed idle gap between consecutive writes.
module opl2_uart_reg_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int WR_GAP     = 32
) (
  input  logic clk,
  input  logic rst,
  opl2_uart_reg_sequencer_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam int GAP_W   = $clog2(WR_GAP + 1);

  typedef enum logic {P_ADDR, P_DATA} parserState_t;
  typedef enum logic {S_IDLE, S_GAP}  issuerState_t;

  parserState_t       parserStateReg, parserStateNext, parserAfterEop;
  logic [7:0]         addrHoldReg, addrHoldNext;
  logic               pushReq, pushAccept, frameErrSet;

  issuerState_t       issuerStateReg, issuerStateNext;
  logic [GAP_W-1:0]   gapCntReg, gapCntNext;
  logic               popFire;

  logic [15:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtrReg, rdPtrReg;
  logic [LEVEL_W-1:0] levelReg;

  logic               oplWrReg;
  logic [7:0]         oplAddrReg, oplDataReg;
  logic               overflowReg, frameErrReg;
  logic [15:0]        wrCountReg;

  // End-of-packet resynchronisation takes effect before any byte in the same cycle.
  assign parserAfterEop = (bus.rx_eop && parserStateReg == P_DATA) ? P_ADDR : parserStateReg;

  // Parser next state: a byte is an address in P_ADDR, completes a pair in P_DATA.
  always_comb begin
    parserStateNext = parserAfterEop;
    addrHoldNext    = addrHoldReg;
    pushReq         = 1'b0;
    frameErrSet     = bus.rx_eop && (parserStateReg == P_DATA);
    if (bus.rx_valid) begin
      if (parserAfterEop == P_ADDR) begin
        addrHoldNext    = bus.rx_data;
        parserStateNext = P_DATA;
      end else begin
        pushReq         = 1'b1;
        parserStateNext = P_ADDR;
      end
    end
  end

  // A full FIFO can still take a pair when the head leaves in the same cycle.
  assign pushAccept = pushReq && ((levelReg < LEVEL_W'(FIFO_DEPTH)) || popFire);

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      parserStateReg <= P_ADDR;
      addrHoldReg    <= 8'h00;
    end else begin
      parserStateReg <= parserStateNext;
      addrHoldReg    <= addrHoldNext;
    end
  end

  // Issuer next state: pop when idle and the core is free, then wait out the gap.
  always_comb begin
    issuerStateNext = issuerStateReg;
    gapCntNext      = gapCntReg;
    popFire         = 1'b0;
    case (issuerStateReg)
      S_IDLE: begin
        if (levelReg != '0 && !bus.opl_busy) begin
          popFire         = 1'b1;
          issuerStateNext = S_GAP;
          gapCntNext      = GAP_W'(WR_GAP);
        end
      end
      S_GAP: begin
        if (gapCntReg == '0) begin
          issuerStateNext = S_IDLE;
        end else begin
          gapCntNext = gapCntReg - GAP_W'(1);
        end
      end
      default: issuerStateNext = S_IDLE;
    endcase
  end

  // Issuer state and gap counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      issuerStateReg <= S_IDLE;
      gapCntReg      <= '0;
    end else begin
      issuerStateReg <= issuerStateNext;
      gapCntReg      <= gapCntNext;
    end
  end

  // Pair storage write port; contents need no reset because the level gates reads.
  always_ff @(posedge clk) begin
    if (pushAccept) begin
      fifoMem[wrPtrReg] <= {addrHoldReg, bus.rx_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      levelReg <= '0;
    end else begin
      if (pushAccept) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (popFire)    rdPtrReg <= rdPtrReg + PTR_W'(1);
      case ({pushAccept, popFire})
        2'b10:   levelReg <= levelReg + LEVEL_W'(1);
        2'b01:   levelReg <= levelReg - LEVEL_W'(1);
        default: levelReg <= levelReg;
      endcase
    end
  end

  // Write strobe, registered FIFO head read, write counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      oplWrReg    <= 1'b0;
      oplAddrReg  <= 8'h00;
      oplDataReg  <= 8'h00;
      wrCountReg  <= 16'h0000;
      overflowReg <= 1'b0;
      frameErrReg <= 1'b0;
    end else begin
      oplWrReg <= popFire;
      if (popFire) begin
        {oplAddrReg, oplDataReg} <= fifoMem[rdPtrReg];
        wrCountReg               <= wrCountReg + 16'd1;
      end
      if (pushReq && !pushAccept) overflowReg <= 1'b1;
      if (frameErrSet)            frameErrReg <= 1'b1;
    end
  end

  assign bus.opl_wr     = oplWrReg;
  assign bus.opl_addr   = oplAddrReg;
  assign bus.opl_data   = oplDataReg;
  assign bus.fifo_level = levelReg;
  assign bus.overflow   = overflowReg;
  assign bus.frame_err  = frameErrReg;
  assign bus.wr_count   = wrCountReg;
endmodule

// File: tb/tb_opl2_uart_reg_sequencer.sv
// Bench for the OPL2 register sequencer: a per-cycle vector table, directed
// corner-case sequences and randomized traffic, all compared against a
// pair-queue reference model.
module tb_opl2_uart_reg_sequencer;
  localparam int FIFO_DEPTH = 8;
  localparam int WR_GAP     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  opl2_uart_reg_sequencer_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  opl2_uart_reg_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .WR_GAP(WR_GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: queued pairs, held address, expected outputs, last write edge.
  logic [15:0] modelQ[$];
  logic        haveAddr;
  logic [7:0]  holdAddr;
  logic        expWr;
  logic [7:0]  expAddr, expData;
  logic        expOvf, expFerr;
  logic [15:0] expCount;
  int          lastWr;
  int          cyc;
  logic        prevWr;

  // Observed writes, for spacing and ordering checks.
  int          dutEdges[$];
  logic [15:0] dutPairs[$];

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       eop;
    logic       busy;
    logic       expWr;
    logic [7:0] expAddr;
    logic [7:0] expData;
    int         expLevel;
    int         expCount;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    haveAddr = 1'b0;
    holdAddr = 8'h00;
    expWr    = 1'b0;
    expAddr  = 8'h00;
    expData  = 8'h00;
    expOvf   = 1'b0;
    expFerr  = 1'b0;
    expCount = 16'h0000;
    lastWr   = -1000;
  endtask

  // Advance one clock: update the model from the inputs being applied, then compare.
  task automatic step();
    int t;
    t = cyc + 1;
    if (rst) begin
      modelReset();
    end else begin
      expWr = 1'b0;
      if (modelQ.size() > 0 && !bus.opl_busy && (t - lastWr >= WR_GAP + 2)) begin
        {expAddr, expData} = modelQ.pop_front();
        expWr    = 1'b1;
        expCount = expCount + 16'd1;
        lastWr   = t;
      end
      if (bus.rx_eop && haveAddr) begin
        haveAddr = 1'b0;
        expFerr  = 1'b1;
      end
      if (bus.rx_valid) begin
        if (!haveAddr) begin
          holdAddr = bus.rx_data;
          haveAddr = 1'b1;
        end else begin
          haveAddr = 1'b0;
          if (modelQ.size() < FIFO_DEPTH) modelQ.push_back({holdAddr, bus.rx_data});
          else expOvf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc = t;
    chk("opl_wr", 32'(bus.opl_wr), 32'(expWr));
    chk("opl_addr", 32'(bus.opl_addr), 32'(expAddr));
    chk("opl_data", 32'(bus.opl_data), 32'(expData));
    chk("fifo_level", 32'(bus.fifo_level), 32'(modelQ.size()));
    chk("overflow", 32'(bus.overflow), 32'(expOvf));
    chk("frame_err", 32'(bus.frame_err), 32'(expFerr));
    chk("wr_count", 32'(bus.wr_count), 32'(expCount));
    if (prevWr && bus.opl_wr) chk("wr_consecutive", 32'(1), 32'(0));
    prevWr = bus.opl_wr;
    if (bus.opl_wr) begin
      dutEdges.push_back(cyc);
      dutPairs.push_back({bus.opl_addr, bus.opl_data});
    end
    bus.rx_valid = 1'b0;
    bus.rx_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sendByte(input logic [7:0] b, input logic eop);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.rx_eop   = eop;
    step();
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    dutEdges.delete();
    dutPairs.delete();
  endtask

  initial begin
    int relCyc;
    logic [15:0] baseCount;

    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_eop   = 1'b0;
    bus.opl_busy = 1'b0;
    cyc          = 0;
    prevWr       = 1'b0;
    modelReset();

    vecs[0] = '{valid: 1'b1, data: 8'h20, eop: 1'b0, busy: 1'b0, expWr: 1'b0, expAddr: 8'h00, expData: 8'h00, expLevel: 0, expCount: 0};
    vecs[1] = '{valid: 1'b1, data: 8'h01, eop: 1'b0, busy: 1'b0, expWr: 1'b0, expAddr: 8'h00, expData: 8'h00, expLevel: 1, expCount: 0};
    vecs[2] = '{valid: 1'b0, data: 8'h00, eop: 1'b0, busy: 1'b0, expWr: 1'b1, expAddr: 8'h20, expData: 8'h01, expLevel: 0, expCount: 1};
    vecs[3] = '{valid: 1'b0, data: 8'h00, eop: 1'b0, busy: 1'b0, expWr: 1'b0, expAddr: 8'h20, expData: 8'h01, expLevel: 0, expCount: 1};

    // Reset state.
    step();
    step();
    rst = 1'b0;
    chk("reset_wr", 32'(bus.opl_wr), 32'(0));
    chk("reset_level", 32'(bus.fifo_level), 32'(0));
    chk("reset_count", 32'(bus.wr_count), 32'(0));

    // Single pair, table driven.
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = vecs[i].valid;
      bus.rx_data  = vecs[i].data;
      bus.rx_eop   = vecs[i].eop;
      bus.opl_busy = vecs[i].busy;
      step();
      chk("vec_wr", 32'(bus.opl_wr), 32'(vecs[i].expWr));
      chk("vec_addr", 32'(bus.opl_addr), 32'(vecs[i].expAddr));
      chk("vec_data", 32'(bus.opl_data), 32'(vecs[i].expData));
      chk("vec_level", 32'(bus.fifo_level), 32'(vecs[i].expLevel));
      chk("vec_count", 32'(bus.wr_count), 32'(vecs[i].expCount));
      $display("vector %0d: wr=%0d addr=%02h data=%02h level=%0d count=%0d", i,
               bus.opl_wr, bus.opl_addr, bus.opl_data, bus.fifo_level, bus.wr_count);
    end
    idle(10);
    chk("single_pulses", 32'(dutEdges.size()), 32'(1));

    // Burst of three pairs, writes spaced WR_GAP+2 apart.
    dutEdges.delete();
    dutPairs.delete();
    baseCount = bus.wr_count;
    sendByte(8'hA0, 1'b0); sendByte(8'h44, 1'b0);
    sendByte(8'hB0, 1'b0); sendByte(8'h32, 1'b0);
    sendByte(8'h40, 1'b0); sendByte(8'h10, 1'b0);
    idle(25);
    chk("burst_pulses", 32'(dutEdges.size()), 32'(3));
    if (dutEdges.size() == 3) begin
      chk("burst_space1", 32'(dutEdges[1] - dutEdges[0]), 32'(6));
      chk("burst_space2", 32'(dutEdges[2] - dutEdges[1]), 32'(6));
      chk("burst_order", 32'(dutPairs[2]), 32'(16'h4010));
    end
    chk("burst_count", 32'(bus.wr_count - baseCount), 32'(3));
    $display("burst: pulses=%0d wr_count=%0d", dutEdges.size(), bus.wr_count);

    // Busy stall.
    dutEdges.delete();
    dutPairs.delete();
    bus.opl_busy = 1'b1;
    sendByte(8'h01, 1'b0); sendByte(8'h11, 1'b0);
    sendByte(8'h02, 1'b0); sendByte(8'h22, 1'b0);
    idle(3);
    chk("stall_level", 32'(bus.fifo_level), 32'(2));
    chk("stall_nowr", 32'(dutEdges.size()), 32'(0));
    relCyc = cyc;
    bus.opl_busy = 1'b0;
    idle(15);
    chk("stall_pulses", 32'(dutEdges.size()), 32'(2));
    if (dutEdges.size() == 2) begin
      chk("stall_first", 32'(dutEdges[0]), 32'(relCyc + 1));
      chk("stall_space", 32'(dutEdges[1] - dutEdges[0]), 32'(WR_GAP + 2));
    end
    $display("busy stall: pulses=%0d", dutEdges.size());

    // Overflow: nine pairs into an eight-deep FIFO.
    bus.opl_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sendByte(8'(8'h10 + i), 1'b0);
      sendByte(8'(8'h80 + i), 1'b0);
    end
    chk("ovf_level", 32'(bus.fifo_level), 32'(8));
    chk("ovf_flag", 32'(bus.overflow), 32'(1));
    dutEdges.delete();
    dutPairs.delete();
    bus.opl_busy = 1'b0;
    idle(60);
    chk("ovf_pulses", 32'(dutEdges.size()), 32'(8));
    if (dutPairs.size() == 8) chk("ovf_last", 32'(dutPairs[7]), 32'(16'h1787));
    $display("overflow: pulses=%0d", dutEdges.size());

    // Resync with eop on its own cycle, then coinciding with the next byte.
    for (int k = 0; k < 2; k++) begin
      doReset();
      sendByte(8'h20, 1'b0);
      if (k == 0) begin
        bus.rx_eop = 1'b1;
        step();
        sendByte(8'h43, 1'b0);
      end else begin
        sendByte(8'h43, 1'b1);
      end
      sendByte(8'h05, 1'b0);
      idle(10);
      chk("resync_ferr", 32'(bus.frame_err), 32'(1));
      chk("resync_pulses", 32'(dutEdges.size()), 32'(1));
      if (dutPairs.size() == 1) chk("resync_pair", 32'(dutPairs[0]), 32'(16'h4305));
      $display("resync %0d: pulses=%0d frame_err=%0d", k, dutEdges.size(), bus.frame_err);
    end

    // Reset mid-burst: in the gap with three pairs queued and a half pair held.
    doReset();
    bus.opl_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sendByte(8'(8'h50 + i), 1'b0);
      sendByte(8'(8'h60 + i), 1'b0);
    end
    sendByte(8'h77, 1'b0);
    bus.opl_busy = 1'b0;
    step();
    chk("mid_wr", 32'(bus.opl_wr), 32'(1));
    chk("mid_level", 32'(bus.fifo_level), 32'(3));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_wr", 32'(bus.opl_wr), 32'(0));
    chk("mid_rst_addr", 32'(bus.opl_addr), 32'(0));
    chk("mid_rst_level", 32'(bus.fifo_level), 32'(0));
    chk("mid_rst_count", 32'(bus.wr_count), 32'(0));
    dutEdges.delete();
    dutPairs.delete();
    idle(20);
    chk("mid_quiet", 32'(dutEdges.size()), 32'(0));
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    idle(8);
    chk("mid_after", 32'(dutEdges.size()), 32'(1));
    if (dutPairs.size() == 1) chk("mid_pair", 32'(dutPairs[0]), 32'(16'h0102));
    $display("reset mid-burst: pulses after reset=%0d", dutEdges.size());

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.rx_valid = ($urandom_range(0, 99) < 50);
      bus.rx_data  = 8'($urandom);
      bus.rx_eop   = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 9) == 0) bus.opl_busy = ~bus.opl_busy;
      rst = ($urandom_range(0, 999) < 3);
      step();
    end
    rst = 1'b0;
    $display("random: wr_count=%0d level=%0d", bus.wr_count, bus.fifo_level);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
